sync_pulse_req_ack: RTL and testbench

SYNC_PULSE_REQ_ACK -- requirements
Module: sync_pulse_req_ack

---
 rtl/sync_pulse_req_ack.sv | 123 ++++++++++++
 tb/tb_sync_pulse_req_ack.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_pulse_req_ack.sv
// sync_pulse_req_ack: clka-side request/acknowledge pulse synchronizer.
// Each ina event is issued as a flip of req_tog. Only one request is outstanding at a time.
// The acknowledge toggle from the clkb domain is synchronized in, and each toggle
// edge completes the outstanding request.
// Optional feature macro SYNC_PULSE_PEND_CNT_EN:
//   defined   -> events arriving while a request is outstanding are queued in a pending counter.
//   undefined -> those events are dropped and pend is tied to zero.
module sync_pulse_req_ack #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PEND_W      = 4
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              ina,
  output logic              req_tog,
  input  logic              ack_tog,
  output logic              busy,
  output logic              done,
  output logic              drop,
  output logic [PEND_W-1:0] pend
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] ack_s;
  logic                   ack_d;
  logic                   ack_evt;
  logic                   pend_any;
  logic                   req_nxt, busy_nxt, done_nxt, drop_nxt;

`ifdef SYNC_PULSE_PEND_CNT_EN
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  logic [PEND_W-1:0] pend_q, pend_nxt;

  assign pend_any = |pend_q;
  assign pend     = pend_q;
`else
  assign pend_any = 1'b0;
  assign pend     = '0;
`endif

  // Synchronize ack_tog, then delay it once more so that each toggle yields a single event.
  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      ack_s <= '0;
      ack_d <= 1'b0;
    end else begin
      ack_s <= {ack_s[SYNC_STAGES-2:0], ack_tog};
      ack_d <= ack_s[SYNC_STAGES-1];
    end
  end

  assign ack_evt = ack_s[SYNC_STAGES-1] ^ ack_d;

  // Next-state and next-output logic; the acknowledge is ignored while IDLE.
  always_comb begin
    state_nxt = state;
    req_nxt   = req_tog;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    drop_nxt  = 1'b0;
`ifdef SYNC_PULSE_PEND_CNT_EN
    pend_nxt  = pend_q;
`endif
    case (state)
      IDLE: begin
        if (ina || pend_any) begin
          req_nxt   = ~req_tog;
          busy_nxt  = 1'b1;
          state_nxt = WAIT_ACK;
`ifdef SYNC_PULSE_PEND_CNT_EN
          // A queued event is consumed only when no new event replaces it this cycle.
          if (!ina && pend_any) pend_nxt = pend_q - PEND_W'(1);
`endif
        end
      end
      WAIT_ACK: begin
        if (ack_evt) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
        if (ina) begin
`ifdef SYNC_PULSE_PEND_CNT_EN
          if (pend_q != PEND_MAX) pend_nxt = pend_q + PEND_W'(1);
          else                    drop_nxt = 1'b1;
`else
          drop_nxt = 1'b1;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      state   <= IDLE;
      req_tog <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      drop    <= 1'b0;
`ifdef SYNC_PULSE_PEND_CNT_EN
      pend_q  <= '0;
`endif
    end else begin
      state   <= state_nxt;
      req_tog <= req_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      drop    <= drop_nxt;
`ifdef SYNC_PULSE_PEND_CNT_EN
      pend_q  <= pend_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_sync_pulse_req_ack.sv
// tb_sync_pulse_req_ack: directed scenarios plus random traffic against a behavioural model.
// The model tracks one outstanding request, an integer queue depth and ack arrival times.
module tb_sync_pulse_req_ack;

  localparam int unsigned S    = 2;
  localparam int unsigned PW   = 4;
  localparam int          PMAX = (1 << PW) - 1;
`ifdef SYNC_PULSE_PEND_CNT_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  logic          clka = 1'b0;
  logic          rsta;
  logic          ina;
  logic          ack_tog;
  logic          req_tog;
  logic          busy;
  logic          done;
  logic          drop;
  logic [PW-1:0] pend;

  sync_pulse_req_ack #(.SYNC_STAGES(S), .PEND_W(PW)) dut (
    .clka    (clka),
    .rsta    (rsta),
    .ina     (ina),
    .req_tog (req_tog),
    .ack_tog (ack_tog),
    .busy    (busy),
    .done    (done),
    .drop    (drop),
    .pend    (pend)
  );

  always #5 clka = ~clka;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state
  bit m_req, m_busy, m_done, m_drop;
  int m_pend;
  int cyc;
  int arr[$];
  bit auto_ack;
  int peer_wait;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".req_tog"}, int'(req_tog), int'(m_req));
    check({tag, ".busy"},    int'(busy),    int'(m_busy));
    check({tag, ".done"},    int'(done),    int'(m_done));
    check({tag, ".drop"},    int'(drop),    int'(m_drop));
    check({tag, ".pend"},    int'(pend),    m_pend);
  endtask

  task automatic model_reset();
    m_req = 0; m_busy = 0; m_done = 0; m_drop = 0; m_pend = 0;
    arr.delete();
  endtask

  // One clka cycle: drive at the falling edge, predict, check 1 time unit after the rising edge.
  task automatic step(input bit in_v, input bit flip);
    bit ack_now;
    @(negedge clka);
    ina = in_v;
    if (flip) begin
      ack_tog = ~ack_tog;
      arr.push_back(cyc + S + 1);
    end
    ack_now = (arr.size() > 0) && (arr[0] == cyc + 1);
    if (ack_now) void'(arr.pop_front());
    m_done = 0;
    m_drop = 0;
    if (!m_busy) begin
      if (in_v || m_pend > 0) begin
        m_req  = ~m_req;
        m_busy = 1;
        if (!in_v && m_pend > 0) m_pend--;
      end
    end else begin
      if (ack_now) begin
        m_done = 1;
        m_busy = 0;
      end
      if (in_v) begin
        if (CNT && m_pend < PMAX) m_pend++;
        else                      m_drop = 1;
      end
    end
    @(posedge clka);
    cyc++;
    #1;
    check_all("step");
  endtask

  // Traffic with the clkb peer answering each new request after a random delay.
  task automatic run(input int n, input int ina_pct);
    bit f;
    for (int i = 0; i < n; i++) begin
      f = 0;
      if (auto_ack && (m_req != ack_tog)) begin
        if (peer_wait > 0) peer_wait--;
        else begin
          f = 1;
          peer_wait = $urandom_range(0, 3);
        end
      end
      step(($urandom % 100) < ina_pct, f);
    end
  endtask

  initial begin
    rsta = 1'b0; ina = 1'b0; ack_tog = 1'b0;
    cyc = 0; auto_ack = 0; peer_wait = 0;
    model_reset();
    #1;
    check_all("reset_async");
    repeat (3) @(posedge clka);
    #1;
    check_all("reset_hold");
    @(negedge clka);
    rsta = 1'b1;

    // Single event, ack with fixed synchronizer latency.
    step(1, 0);
    check("first_req", int'(req_tog), 1);
    step(0, 1);
    for (int i = 0; i < S; i++) step(0, 0);
    check("latency_done", int'(done), 1);
    step(0, 0);

    // Three events queued behind an outstanding request, then drained.
    step(1, 0);
    for (int i = 0; i < 3; i++) step(1, 0);
    check("queued3", int'(pend), CNT ? 3 : 0);
    auto_ack = 1;
    run(60, 0);
    auto_ack = 0;

    // Burst long enough to saturate the queue.
    step(1, 0);
    for (int i = 0; i < PMAX + 4; i++) step(1, 0);
    auto_ack = 1;
    run(200, 0);
    auto_ack = 0;

    // Event and ack on the same edge with nothing queued.
    step(1, 0);
    step(0, 1);
    for (int i = 0; i < S - 1; i++) step(0, 0);
    step(1, 0);
    check("same_edge_done", int'(done), 1);
    step(0, 0);
    step(0, 0);
    auto_ack = 1;
    run(20, 0);
    auto_ack = 0;

    // Spurious acknowledge toggles while idle must be ignored.
    step(0, 1);
    for (int i = 0; i < S + 3; i++) step(0, 0);
    step(0, 1);
    for (int i = 0; i < S + 3; i++) step(0, 0);

    // Random traffic.
    auto_ack = 1;
    run(1500, 30);
    run(400, 80);
    run(300, 0);
    auto_ack = 0;

    // Reset in the middle of an outstanding request with two events queued.
    step(1, 0);
    step(1, 0);
    step(1, 0);
    @(negedge clka);
    #2;
    ina = 1'b0;
    rsta = 1'b0;
    ack_tog = 1'b0;
    model_reset();
    #1;
    check_all("mid_reset");
    repeat (2) @(posedge clka);
    @(negedge clka);
    rsta = 1'b1;
    step(0, 1);
    for (int i = 0; i < S + 3; i++) step(0, 0);
    step(0, 1);
    for (int i = 0; i < S + 2; i++) step(0, 0);
    auto_ack = 1;
    run(100, 40);
    run(50, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
